// File: rtl/cheri_pkg.sv
// Shared types and helpers for the core/stkz LSU arbiter.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package cheri_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE      = 2'd0,
      ARB_HOLD_CORE = 2'd1,
      ARB_HOLD_STKZ = 2'd2
   } stkz_arb_fsm_t;

   localparam logic OWNER_CORE = 1'b0;
   localparam logic OWNER_STKZ = 1'b1;

   // Word-granular check against the not-yet-zeroed window [base, ptr).
   function automatic logic in_stkz_window(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input logic [31:0] ptr);
      return (addr[31:2] >= base[31:2]) && (addr[31:2] < ptr[31:2]);
   endfunction

endpackage

// File: rtl/cheri_owner_fifo.sv
// Small FIFO recording the owner of each accepted-but-unanswered LSU request.
// Latency: head is combinational from storage; push visible at head the cycle after.
// Backpressure: push is ignored when full unless a pop happens the same cycle.
// Ports: clk_i/rst_i (sync, active-high), push_i/push_dat_i, pop_i,
//        full_o/empty_o status, head_dat_o oldest entry.
module cheri_owner_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_dat_i,
   input  logic             pop_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [WIDTH-1:0] head_dat_o
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q;
   logic [PW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign full_o     = (count_q == CW'(DEPTH));
   assign empty_o    = (count_q == '0);
   assign do_pop     = pop_i & ~empty_o;
   // When full, the slot being pushed is the one being popped this cycle.
   assign do_push    = push_i & (~full_o | do_pop);
   assign head_dat_o = mem_q[rd_ptr_q];

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_dat_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/cheri_stkz_lsu_arb.sv
// Arbitrates one LSU request port between the core and the stack-zeroization engine.
// Latency: zero-cycle request/grant path; responses routed combinationally to the head owner.
// Backpressure: selection held until lsu_gnt_i; nothing issued while owner FIFO full (unless popping).
// Ports: core_* request/response side, stkz_* request/response side and window (base/ptr/active),
//        lsu_* muxed request and raw response, arb_err_o sticky spurious-response flag.
module cheri_stkz_lsu_arb
   import cheri_pkg::*;
#(
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter int unsigned CORE_BURST_MAX  = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        core_req_i,
   input  logic        core_we_i,
   input  logic        core_is_cap_i,
   input  logic [31:0] core_addr_i,
   input  logic [32:0] core_wdata_i,
   output logic        core_gnt_o,
   output logic        core_hazard_o,
   output logic        core_resp_valid_o,
   output logic        core_resp_err_o,
   output logic [32:0] core_rdata_o,
   input  logic        stkz_req_i,
   input  logic        stkz_we_i,
   input  logic        stkz_is_cap_i,
   input  logic [31:0] stkz_addr_i,
   input  logic [32:0] stkz_wdata_i,
   input  logic        stkz_active_i,
   input  logic [31:0] stkz_ptr_i,
   input  logic [31:0] stkz_base_i,
   output logic        stkz_req_done_o,
   output logic        stkz_resp_valid_o,
   output logic        stkz_resp_err_o,
   output logic        lsu_req_o,
   output logic        lsu_we_o,
   output logic        lsu_is_cap_o,
   output logic [31:0] lsu_addr_o,
   output logic [32:0] lsu_wdata_o,
   input  logic        lsu_gnt_i,
   input  logic        lsu_resp_valid_i,
   input  logic        lsu_resp_err_i,
   input  logic [32:0] lsu_rdata_i,
   output logic        arb_err_o
);

   localparam int unsigned BW = $clog2(CORE_BURST_MAX + 1);

   stkz_arb_fsm_t state_q;
   logic [BW-1:0] burst_q;
   logic          arb_err_q;

   logic          sel;
   logic          req_pick;
   logic          core_elig;
   logic          lsu_fire;
   logic          fifo_full;
   logic          fifo_empty;
   logic          fifo_head;
   logic          pop;
   logic          can_issue;

   assign core_hazard_o = ~rst_i & core_req_i & stkz_active_i
                        & in_stkz_window(core_addr_i, stkz_base_i, stkz_ptr_i);
   assign core_elig     = core_req_i & ~core_hazard_o;

   assign pop       = ~rst_i & lsu_resp_valid_i & ~fifo_empty;
   assign can_issue = ~fifo_full | pop;

   always_comb begin
      sel      = OWNER_CORE;
      req_pick = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            // Burst limit reached: stkz wins even over an eligible core.
            if (core_elig && !(stkz_req_i && burst_q == BW'(CORE_BURST_MAX))) begin
               sel      = OWNER_CORE;
               req_pick = 1'b1;
            end else if (stkz_req_i) begin
               sel      = OWNER_STKZ;
               req_pick = 1'b1;
            end
         end
         ARB_HOLD_CORE: begin
            sel      = OWNER_CORE;
            req_pick = core_req_i;
         end
         ARB_HOLD_STKZ: begin
            sel      = OWNER_STKZ;
            req_pick = stkz_req_i;
         end
         default: ;
      endcase
   end

   assign lsu_req_o    = ~rst_i & req_pick & can_issue;
   assign lsu_fire     = lsu_req_o & lsu_gnt_i;
   assign lsu_we_o     = lsu_req_o & ((sel == OWNER_STKZ) ? stkz_we_i : core_we_i);
   assign lsu_is_cap_o = lsu_req_o & ((sel == OWNER_STKZ) ? stkz_is_cap_i : core_is_cap_i);
   assign lsu_addr_o   = !lsu_req_o ? '0 : ((sel == OWNER_STKZ) ? stkz_addr_i : core_addr_i);
   assign lsu_wdata_o  = !lsu_req_o ? '0 : ((sel == OWNER_STKZ) ? stkz_wdata_i : core_wdata_i);

   assign core_gnt_o      = lsu_fire & (sel == OWNER_CORE);
   assign stkz_req_done_o = lsu_fire & (sel == OWNER_STKZ);

   assign core_resp_valid_o = pop & (fifo_head == OWNER_CORE);
   assign stkz_resp_valid_o = pop & (fifo_head == OWNER_STKZ);
   assign core_resp_err_o   = core_resp_valid_o & lsu_resp_err_i;
   assign stkz_resp_err_o   = stkz_resp_valid_o & lsu_resp_err_i;
   assign core_rdata_o      = core_resp_valid_o ? lsu_rdata_i : '0;
   assign arb_err_o         = arb_err_q;

   cheri_owner_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .WIDTH (1)
   ) u_owner_fifo (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .push_i     (lsu_fire),
      .push_dat_i (sel),
      .pop_i      (pop),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty),
      .head_dat_o (fifo_head)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ARB_IDLE;
         burst_q   <= '0;
         arb_err_q <= 1'b0;
      end else begin
         case (state_q)
            ARB_IDLE: begin
               if (lsu_req_o && !lsu_gnt_i) begin
                  state_q <= (sel == OWNER_STKZ) ? ARB_HOLD_STKZ : ARB_HOLD_CORE;
               end
            end
            ARB_HOLD_CORE: if (lsu_fire || !core_req_i) state_q <= ARB_IDLE;
            // stkz may abort by dropping its request.
            ARB_HOLD_STKZ: if (lsu_fire || !stkz_req_i) state_q <= ARB_IDLE;
            default:       state_q <= ARB_IDLE;
         endcase

         if (stkz_req_done_o || !stkz_req_i) begin
            burst_q <= '0;
         end else if (core_gnt_o && burst_q != BW'(CORE_BURST_MAX)) begin
            burst_q <= burst_q + BW'(1);
         end

         if (lsu_resp_valid_i && fifo_empty) begin
            arb_err_q <= 1'b1;
         end
      end
   end

   core_hold_stable: assert property (@(posedge clk_i) disable iff (rst_i)
      (state_q == ARB_HOLD_CORE) |-> core_req_i);

endmodule

// File: tb/tb_cheri_stkz_lsu_arb.sv
// Directed bench for the core/stkz LSU arbiter.
// Latency: inputs driven 1ns after posedge, outputs sampled 5ns after posedge.
// Backpressure: LSU grant and response driven directly by the stimulus steps.
module tb_cheri_stkz_lsu_arb;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        core_req_i, core_we_i, core_is_cap_i;
   logic [31:0] core_addr_i;
   logic [32:0] core_wdata_i;
   logic        core_gnt_o, core_hazard_o, core_resp_valid_o, core_resp_err_o;
   logic [32:0] core_rdata_o;
   logic        stkz_req_i, stkz_we_i, stkz_is_cap_i, stkz_active_i;
   logic [31:0] stkz_addr_i, stkz_ptr_i, stkz_base_i;
   logic [32:0] stkz_wdata_i;
   logic        stkz_req_done_o, stkz_resp_valid_o, stkz_resp_err_o;
   logic        lsu_req_o, lsu_we_o, lsu_is_cap_o;
   logic [31:0] lsu_addr_o;
   logic [32:0] lsu_wdata_o;
   logic        lsu_gnt_i, lsu_resp_valid_i, lsu_resp_err_i;
   logic [32:0] lsu_rdata_i;
   logic        arb_err_o;

   int total = 0;
   int bad   = 0;

   always #5 clk_i = ~clk_i;

   cheri_stkz_lsu_arb #(.MAX_OUTSTANDING(2), .CORE_BURST_MAX(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .core_req_i(core_req_i), .core_we_i(core_we_i), .core_is_cap_i(core_is_cap_i),
      .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i),
      .core_gnt_o(core_gnt_o), .core_hazard_o(core_hazard_o),
      .core_resp_valid_o(core_resp_valid_o), .core_resp_err_o(core_resp_err_o),
      .core_rdata_o(core_rdata_o),
      .stkz_req_i(stkz_req_i), .stkz_we_i(stkz_we_i), .stkz_is_cap_i(stkz_is_cap_i),
      .stkz_addr_i(stkz_addr_i), .stkz_wdata_i(stkz_wdata_i),
      .stkz_active_i(stkz_active_i), .stkz_ptr_i(stkz_ptr_i), .stkz_base_i(stkz_base_i),
      .stkz_req_done_o(stkz_req_done_o), .stkz_resp_valid_o(stkz_resp_valid_o),
      .stkz_resp_err_o(stkz_resp_err_o),
      .lsu_req_o(lsu_req_o), .lsu_we_o(lsu_we_o), .lsu_is_cap_o(lsu_is_cap_o),
      .lsu_addr_o(lsu_addr_o), .lsu_wdata_o(lsu_wdata_o),
      .lsu_gnt_i(lsu_gnt_i), .lsu_resp_valid_i(lsu_resp_valid_i),
      .lsu_resp_err_i(lsu_resp_err_i), .lsu_rdata_i(lsu_rdata_i),
      .arb_err_o(arb_err_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic quiet();
      core_req_i = 0; core_we_i = 0; core_is_cap_i = 0;
      core_addr_i = '0; core_wdata_i = '0;
      stkz_req_i = 0; stkz_we_i = 0; stkz_is_cap_i = 0;
      stkz_addr_i = '0; stkz_wdata_i = '0;
      stkz_active_i = 0; stkz_ptr_i = '0; stkz_base_i = '0;
      lsu_gnt_i = 0; lsu_resp_valid_i = 0; lsu_resp_err_i = 0; lsu_rdata_i = '0;
   endtask

   // Move to the sampling point of the current cycle.
   task automatic sample();
      #4;
   endtask

   // Finish the current cycle and land 1ns after the next posedge.
   task automatic next();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      quiet();
      rst_i = 1;
      next();
      next();
      sample();
      chk("rst_lsu_req", 64'(lsu_req_o), 64'd0);
      chk("rst_core_gnt", 64'(core_gnt_o), 64'd0);
      chk("rst_arb_err", 64'(arb_err_o), 64'd0);
      chk("rst_resp_valid", 64'({core_resp_valid_o, stkz_resp_valid_o}), 64'd0);
      next();
      rst_i = 0;

      // Core-only back-to-back reads, responses one cycle behind grants.
      for (int i = 0; i < 4; i++) begin
         quiet();
         core_req_i       = (i < 3);
         core_addr_i      = 32'h1000 + 32'(4 * i);
         lsu_gnt_i        = 1;
         lsu_resp_valid_i = (i > 0);
         lsu_rdata_i      = 33'h0A0 + 33'(i);
         lsu_resp_err_i   = (i == 2);
         sample();
         if (i < 3) begin
            chk("b2b_core_gnt", 64'(core_gnt_o), 64'd1);
            chk("b2b_lsu_addr", 64'(lsu_addr_o), 64'h1000 + 64'(4 * i));
         end
         if (i > 0) begin
            chk("b2b_core_resp", 64'(core_resp_valid_o), 64'd1);
            chk("b2b_core_rdata", 64'(core_rdata_o), 64'h0A0 + 64'(i));
            chk("b2b_core_err", 64'(core_resp_err_o), 64'(i == 2));
            chk("b2b_stkz_resp", 64'(stkz_resp_valid_o), 64'd0);
         end
         next();
      end

      // Stack window hazard: [0x100, 0x140).
      quiet();
      stkz_active_i = 1; stkz_base_i = 32'h100; stkz_ptr_i = 32'h140;
      core_req_i = 1; core_addr_i = 32'h13C; lsu_gnt_i = 1;
      sample();
      chk("haz_top_hazard", 64'(core_hazard_o), 64'd1);
      chk("haz_top_gnt", 64'(core_gnt_o), 64'd0);
      chk("haz_top_lsu_req", 64'(lsu_req_o), 64'd0);
      next();
      core_addr_i = 32'h100;
      sample();
      chk("haz_base_hazard", 64'(core_hazard_o), 64'd1);
      next();
      core_addr_i = 32'h140;
      sample();
      chk("haz_ptr_hazard", 64'(core_hazard_o), 64'd0);
      chk("haz_ptr_gnt", 64'(core_gnt_o), 64'd1);
      next();
      quiet();
      lsu_resp_valid_i = 1; lsu_rdata_i = 33'h1_0000_0001;
      sample();
      chk("haz_resp_core", 64'(core_resp_valid_o), 64'd1);
      chk("haz_resp_rdata", 64'(core_rdata_o), 64'h1_0000_0001);
      next();

      // Both requesting continuously: C,C,C,C,S repeating.
      for (int i = 0; i < 11; i++) begin
         quiet();
         core_req_i       = (i < 10);
         core_addr_i      = 32'h2000;
         stkz_req_i       = (i < 10);
         stkz_we_i        = 1;
         stkz_addr_i      = 32'h800;
         lsu_gnt_i        = 1;
         lsu_resp_valid_i = (i > 0);
         sample();
         if (i < 10) begin
            chk("burst_core_gnt", 64'(core_gnt_o), 64'((i % 5) != 4));
            chk("burst_stkz_done", 64'(stkz_req_done_o), 64'((i % 5) == 4));
         end
         if (i > 0) begin
            chk("burst_stkz_resp", 64'(stkz_resp_valid_o), 64'(((i - 1) % 5) == 4));
            chk("burst_core_resp", 64'(core_resp_valid_o), 64'(((i - 1) % 5) != 4));
         end
         next();
      end

      // stkz held without grant while core raises its request.
      quiet();
      stkz_req_i = 1; stkz_we_i = 1; stkz_addr_i = 32'h200;
      sample();
      chk("hold_addr0", 64'(lsu_addr_o), 64'h200);
      chk("hold_we0", 64'(lsu_we_o), 64'd1);
      next();
      for (int i = 0; i < 2; i++) begin
         core_req_i = 1; core_addr_i = 32'h3000;
         sample();
         chk("hold_addr", 64'(lsu_addr_o), 64'h200);
         chk("hold_core_gnt", 64'(core_gnt_o), 64'd0);
         next();
      end
      lsu_gnt_i = 1;
      sample();
      chk("hold_stkz_done", 64'(stkz_req_done_o), 64'd1);
      chk("hold_core_gnt_g", 64'(core_gnt_o), 64'd0);
      next();
      stkz_req_i = 0; lsu_resp_valid_i = 1;
      sample();
      chk("hold_then_core_gnt", 64'(core_gnt_o), 64'd1);
      chk("hold_then_addr", 64'(lsu_addr_o), 64'h3000);
      chk("hold_stkz_resp", 64'(stkz_resp_valid_o), 64'd1);
      next();
      quiet();
      lsu_resp_valid_i = 1;
      sample();
      chk("hold_core_resp", 64'(core_resp_valid_o), 64'd1);
      next();

      // Owner FIFO full stalls new requests until a response frees a slot.
      quiet();
      core_req_i = 1; core_addr_i = 32'h10; lsu_gnt_i = 1;
      sample();
      chk("full_gnt0", 64'(core_gnt_o), 64'd1);
      next();
      core_addr_i = 32'h14;
      sample();
      chk("full_gnt1", 64'(core_gnt_o), 64'd1);
      next();
      core_addr_i = 32'h18;
      sample();
      chk("full_lsu_req", 64'(lsu_req_o), 64'd0);
      chk("full_gnt2", 64'(core_gnt_o), 64'd0);
      next();
      lsu_resp_valid_i = 1; lsu_rdata_i = 33'h77;
      sample();
      chk("full_reissue_req", 64'(lsu_req_o), 64'd1);
      chk("full_reissue_gnt", 64'(core_gnt_o), 64'd1);
      chk("full_reissue_addr", 64'(lsu_addr_o), 64'h18);
      chk("full_resp", 64'(core_resp_valid_o), 64'd1);
      next();
      core_req_i = 0; lsu_resp_err_i = 1;
      sample();
      chk("full_resp_err", 64'(core_resp_err_o), 64'd1);
      next();
      lsu_resp_err_i = 0;
      sample();
      chk("full_resp_last", 64'(core_resp_valid_o), 64'd1);
      next();

      // Response with nothing outstanding.
      quiet();
      lsu_resp_valid_i = 1; lsu_rdata_i = 33'h55; lsu_resp_err_i = 1;
      sample();
      chk("spur_arb_err_before", 64'(arb_err_o), 64'd0);
      chk("spur_resp_valid", 64'({core_resp_valid_o, stkz_resp_valid_o}), 64'd0);
      chk("spur_core_rdata", 64'(core_rdata_o), 64'd0);
      next();
      quiet();
      sample();
      chk("spur_arb_err_set", 64'(arb_err_o), 64'd1);
      next();
      sample();
      chk("spur_arb_err_sticky", 64'(arb_err_o), 64'd1);
      next();
      rst_i = 1;
      next();
      rst_i = 0;
      sample();
      chk("spur_arb_err_clr", 64'(arb_err_o), 64'd0);
      next();

      // Reset while a request is outstanding: its response becomes spurious.
      core_req_i = 1; core_addr_i = 32'h40; lsu_gnt_i = 1;
      sample();
      chk("rstmid_gnt", 64'(core_gnt_o), 64'd1);
      next();
      quiet();
      rst_i = 1;
      next();
      rst_i = 0;
      lsu_resp_valid_i = 1;
      sample();
      chk("rstmid_resp_dropped", 64'(core_resp_valid_o), 64'd0);
      next();
      quiet();
      sample();
      chk("rstmid_arb_err", 64'(arb_err_o), 64'd1);
      next();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
